// File: rtl/i2c_audio_config_block_pkg.sv
// Shared constants, FSM encodings and table helpers for the WM8731 I2C
// configuration block: init table, codec address, volume map, phase lengths.
package i2c_audio_config_block_pkg;

    localparam logic [7:0] CODEC_ADDR = 8'h34;
    localparam logic [3:0] LAST_WORD  = 4'd9;
    localparam logic [3:0] VOL_WORD   = 4'd3;
    localparam logic [8:0] VOL_RESET  = 9'h179;

    // Last cycle index of each timed phase (counter runs 0..LAST)
    localparam logic [1:0] START_LAST = 2'd1;
    localparam logic [1:0] PHASE_LAST = 2'd3;
    localparam logic [1:0] ACK_SAMPLE = 2'd2;
    localparam logic [1:0] STOP_LAST  = 2'd2;
    localparam logic [1:0] GAP_LAST   = 2'd3;
    localparam logic [1:0] LAST_BYTE  = 2'd2;

    typedef enum logic [2:0] {
        IDLE, START, BIT, ACK, STOP, GAP, DONE
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE, SEQ_INIT, SEQ_DONE, SEQ_UPDATE
    } seq_t;

    function automatic logic [8:0] vol_map(input logic [1:0] sel);
        logic [8:0] v;
        case (sel)
            2'b00:   v = 9'h130;
            2'b01:   v = 9'h15A;
            2'b10:   v = 9'h16A;
            default: v = 9'h179;
        endcase
        return v;
    endfunction

    // Word 3 is the headphone register; bit8 (LRHPBOTH) keeps R3 in step
    function automatic logic [15:0] init_word(input logic [3:0] idx,
                                              input logic [8:0] v);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0017;
            4'd2:    w = 16'h0217;
            4'd3:    w = {7'h02, v};
            4'd4:    w = 16'h0812;
            4'd5:    w = 16'h0A00;
            4'd6:    w = 16'h0C00;
            4'd7:    w = 16'h0E02;
            4'd8:    w = 16'h1000;
            4'd9:    w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/i2c_audio_config_block_word_writer.sv
// i2c_word_writer: sends one START, 3 bytes with ACK slots, STOP, GAP.
// Ports: clk/rst, start+frame in; scl, sda_low (open-drain pull), done, nack.
module i2c_word_writer
    import i2c_audio_config_block_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] frame,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_low,
    output logic        done,
    output logic        nack
);

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [1:0]  byte_idx, byte_idx_nx;
    logic [23:0] shreg, shreg_nx;
    logic        nack_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd7;
            byte_idx <= '0;
            shreg    <= '0;
            nack     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            byte_idx <= byte_idx_nx;
            shreg    <= shreg_nx;
            nack     <= nack_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + 2'd1;
        bit_idx_nx  = bit_idx;
        byte_idx_nx = byte_idx;
        shreg_nx    = shreg;
        nack_nx     = nack;
        scl         = 1'b1;
        sda_low     = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = START;
                    shreg_nx = frame;
                    nack_nx  = 1'b0;
                end
            end
            START: begin
                sda_low = 1'b1;
                scl     = (cnt == 2'd0);
                if (cnt == START_LAST) begin
                    state_nx    = BIT;
                    cnt_nx      = '0;
                    bit_idx_nx  = 3'd7;
                    byte_idx_nx = '0;
                end
            end
            BIT: begin
                // SCL high in the middle two quarters only
                scl     = cnt[0] ^ cnt[1];
                sda_low = ~shreg[23];
                if (cnt == PHASE_LAST) begin
                    shreg_nx   = {shreg[22:0], 1'b0};
                    bit_idx_nx = bit_idx - 3'd1;
                    if (bit_idx == 3'd0) state_nx = ACK;
                end
            end
            ACK: begin
                scl = cnt[0] ^ cnt[1];
                if (cnt == ACK_SAMPLE && sda_in) nack_nx = 1'b1;
                if (cnt == PHASE_LAST) begin
                    if (nack || byte_idx == LAST_BYTE) begin
                        state_nx = STOP;
                    end else begin
                        state_nx    = BIT;
                        byte_idx_nx = byte_idx + 2'd1;
                    end
                end
            end
            STOP: begin
                scl     = (cnt != 2'd0);
                sda_low = (cnt != STOP_LAST);
                if (cnt == STOP_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    done = 1'b1;
                    // Back-to-back words chain straight into START
                    if (start) begin
                        state_nx = START;
                        shreg_nx = frame;
                        nack_nx  = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/i2c_audio_config_block.sv
// WM8731 codec configurator: sends the 10-word init table, then rewrites
// R2 on VOLUME changes. Ports: clk_i2c, reset, VOLUME, I2C bus, vol, init_done.
module i2c_audio_config_block
    import i2c_audio_config_block_pkg::*;
(
    input  logic       clk_i2c,
    input  logic       reset,
    input  logic [1:0] VOLUME,
    output logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [8:0] vol,
    output logic       init_done
);

    seq_t        seq, seq_nx;
    logic [3:0]  idx, idx_nx;
    logic [8:0]  vol_nx, vol_req;
    logic        init_done_nx;
    logic        start, r2;
    logic [15:0] word;
    logic        done, nack, scl, sda_low;

    assign vol_req  = vol_map(VOLUME);
    assign I2C_SCLK = scl;
    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk_i2c or posedge reset) begin
        if (reset) begin
            seq       <= SEQ_IDLE;
            idx       <= '0;
            vol       <= VOL_RESET;
            init_done <= 1'b0;
        end else begin
            seq       <= seq_nx;
            idx       <= idx_nx;
            vol       <= vol_nx;
            init_done <= init_done_nx;
        end
    end

    always_comb begin
        seq_nx       = seq;
        idx_nx       = idx;
        vol_nx       = vol;
        init_done_nx = init_done;
        start        = 1'b0;
        unique case (seq)
            SEQ_IDLE: begin
                start  = 1'b1;
                idx_nx = '0;
                seq_nx = SEQ_INIT;
            end
            SEQ_INIT: begin
                if (done) begin
                    if (nack) begin
                        start = 1'b1;
                    end else if (idx == LAST_WORD) begin
                        seq_nx       = SEQ_DONE;
                        init_done_nx = 1'b1;
                    end else begin
                        idx_nx = idx + 4'd1;
                        start  = 1'b1;
                    end
                end
            end
            SEQ_DONE: begin
                if (vol_req != vol) begin
                    start  = 1'b1;
                    seq_nx = SEQ_UPDATE;
                end
            end
            SEQ_UPDATE: begin
                if (done) begin
                    if (nack) start = 1'b1;
                    else seq_nx = SEQ_DONE;
                end
            end
            default: seq_nx = SEQ_IDLE;
        endcase
        // After init every write is the headphone register
        r2 = (seq == SEQ_DONE) || (seq == SEQ_UPDATE) ||
             (idx_nx == VOL_WORD);
        word = r2 ? init_word(VOL_WORD, vol_req)
                  : init_word(idx_nx, vol_req);
        // vol follows VOLUME only at the start of an R2 write
        if (start && r2) vol_nx = vol_req;
    end

    i2c_word_writer u_writer (
        .clk     (clk_i2c),
        .rst     (reset),
        .start   (start),
        .frame   ({CODEC_ADDR, word}),
        .sda_in  (I2C_SDAT),
        .scl     (scl),
        .sda_low (sda_low),
        .done    (done),
        .nack    (nack)
    );

endmodule

// File: tb/tb_i2c_audio_config_block.sv
// Bench for i2c_audio_config_block: I2C slave decoder + scoreboard of
// expected frames, bus-rule monitor, randomized volume traffic.
module tb_i2c_audio_config_block;

    typedef struct {
        int          n;
        logic [23:0] data;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] volume;
    wire        scl;
    wire        sda;
    logic [8:0] vol;
    logic       init_done;
    logic       slave_pull = 1'b0;
    logic       probe_pull = 1'b0;

    int checks   = 0;
    int failures = 0;

    frame_t exp_q[$];
    int     frames_seen = 0;
    int     nack_arm = 0;
    int     nack_used = 0;

    logic [15:0] ref_words [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0400,
                                    16'h0812, 16'h0A00, 16'h0C00, 16'h0E02,
                                    16'h1000, 16'h1201};

    pullup (sda);
    assign sda = (slave_pull && !rst) ? 1'b0 : 1'bz;
    assign sda = probe_pull ? 1'b0 : 1'bz;

    i2c_audio_config_block dut (
        .clk_i2c   (clk),
        .reset     (rst),
        .VOLUME    (volume),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda),
        .vol       (vol),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ref_vol(input logic [1:0] v);
        case (v)
            2'd0:    return 9'h130;
            2'd1:    return 9'h15A;
            2'd2:    return 9'h16A;
            default: return 9'h179;
        endcase
    endfunction

    task automatic push_words(input int count, input logic [8:0] v);
        logic [15:0] w;
        for (int i = 0; i < count; i++) begin
            w = (i == 3) ? (16'h0400 | {7'd0, v}) : ref_words[i];
            exp_q.push_back('{n: 3, data: {8'h34, w}});
        end
    endtask

    task automatic push_r2(input logic [8:0] v);
        exp_q.push_back('{n: 3, data: {8'h34, 16'h0400 | {7'd0, v}}});
    endtask

    // ---------------- slave model, decoder and scoreboard monitor
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic        s_scl, s_sda;
    logic        in_frame = 1'b0;
    int          bitcnt, nbytes;
    logic [7:0]  cur;
    logic [23:0] fdata;
    frame_t      e;

    always @(negedge clk) begin
        s_scl = scl;
        s_sda = sda;
        if (rst) begin
            in_frame   = 1'b0;
            slave_pull = 1'b0;
            s_scl      = 1'b1;
            s_sda      = 1'b1;
        end else begin
            if (s_sda !== p_sda) begin
                if (p_scl && s_scl) begin
                    if (!s_sda) begin
                        check("start_outside_frame", in_frame, 0);
                        in_frame = 1'b1;
                        bitcnt   = 0;
                        nbytes   = 0;
                        fdata    = '0;
                    end else if (in_frame) begin
                        check("stop_on_byte_boundary", bitcnt, 1);
                        in_frame = 1'b0;
                        frames_seen++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", fdata, 0);
                            check("unexpected_frame_len", nbytes, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_bytes", nbytes, e.n);
                            check("frame_data", fdata, e.data);
                        end
                    end
                end else begin
                    check("sda_change_scl_low", {p_scl, s_scl}, 0);
                end
            end
            if (in_frame && !p_scl && s_scl) begin
                if (bitcnt < 8) begin
                    cur = {cur[6:0], s_sda};
                    bitcnt++;
                end else begin
                    case (nbytes)
                        0:       fdata[23:16] = cur;
                        1:       fdata[15:8]  = cur;
                        default: fdata[7:0]   = cur;
                    endcase
                    nbytes++;
                    bitcnt = 0;
                end
            end
            if (in_frame && p_scl && !s_scl) begin
                if (bitcnt == 8) begin
                    if (nbytes == 0 && nack_used != nack_arm) begin
                        nack_used++;
                        slave_pull = 1'b0;
                    end else begin
                        slave_pull = 1'b1;
                    end
                end else begin
                    slave_pull = 1'b0;
                end
            end
        end
        p_scl = s_scl;
        p_sda = s_sda;
    end

    // ---------------- helpers with bounded waits
    task automatic assert_reset();
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_init(input int budget, input string name);
        int n = 0;
        while (!init_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, init_done, 1);
    endtask

    task automatic wait_frames(input int target, input int budget,
                               input string name);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, frames_seen >= target, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, k;
        logic [1:0] v0, v1;

        rst    = 1'b1;
        volume = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_vol", vol, 9'h179);
        check("rst_init_done", init_done, 0);
        probe_pull = 1'b1;
        #1 check("rst_sda_not_driven_high", sda, 0);
        probe_pull = 1'b0;
        #1;

        // Power-up sequence, VOLUME=11, always-ACK slave
        push_words(10, 9'h179);
        base = frames_seen;
        release_reset();
        n = 0;
        while (!init_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        // first edge leaves IDLE, then 10 words of 117 cycles
        check("init_done_latency", n - 1, 1170);
        wait_idle(300, "init_frames_drained");
        check("init_frame_count", frames_seen - base, 10);
        check("init_vol", vol, 9'h179);

        // VOLUME 11 -> 01 after init, then random changes
        base = frames_seen;
        push_r2(9'h15A);
        @(negedge clk);
        volume = 2'b01;
        wait_idle(400, "vol_update_frame");
        check("vol_after_update", vol, 9'h15A);
        for (int i = 0; i < 3; i++) begin
            v1 = 2'($urandom_range(0, 3));
            while (v1 == volume) v1 = 2'($urandom_range(0, 3));
            push_r2(ref_vol(v1));
            @(negedge clk);
            volume = v1;
            wait_idle(400, "vol_random_update");
            check("vol_random_value", vol, ref_vol(v1));
        end
        repeat (300) @(negedge clk);
        check("vol_update_frame_count", frames_seen - base, 4);
        check("init_done_held", init_done, 1);

        // NACK on the first address byte once
        v0 = 2'($urandom_range(0, 3));
        assert_reset();
        volume = v0;
        #1 check("rst_clears_init_done", init_done, 0);
        exp_q.push_back('{n: 1, data: 24'h340000});
        push_words(10, ref_vol(v0));
        nack_arm++;
        base = frames_seen;
        release_reset();
        wait_init(2000, "nack_init_done");
        wait_idle(300, "nack_frames_drained");
        check("nack_frame_count", frames_seen - base, 11);
        check("nack_vol", vol, ref_vol(v0));

        // Reset mid-bit of word 5
        v0 = 2'($urandom_range(0, 3));
        assert_reset();
        volume = v0;
        push_words(5, ref_vol(v0));
        base = frames_seen;
        release_reset();
        k = $urandom_range(0, 100);
        repeat (5 * 117 + 3 + k) @(posedge clk);
        assert_reset();
        #1;
        check("midword_rst_scl", scl, 1);
        check("midword_rst_sda", sda, 1);
        check("midword_frames_before", frames_seen - base, 5);
        check("midword_queue", exp_q.size(), 0);

        // Restart from word 0; VOLUME change during word 7
        push_words(10, ref_vol(v0));
        base = frames_seen;
        repeat (2) @(negedge clk);
        release_reset();
        wait_frames(base + 7, 1200, "reach_word7");
        repeat ($urandom_range(6, 100)) @(negedge clk);
        v1 = 2'($urandom_range(0, 3));
        while (v1 == v0) v1 = 2'($urandom_range(0, 3));
        push_r2(ref_vol(v1));
        volume = v1;
        wait_init(1000, "word7_init_done");
        wait_idle(400, "word7_frames_drained");
        check("word7_vol", vol, ref_vol(v1));
        repeat (200) @(negedge clk);
        check("word7_frame_count", frames_seen - base, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_audio_config_block.md
I2C_AUDIO_CONFIG_BLOCK -- requirements
Module: i2c_audio_config

Interface
REQ-001 SHALL have port clk_i2c  input  1  sole clock, 10 kHz I2C base clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port VOLUME  input  2  headphone volume select, sampled synchronously.
REQ-004 SHALL have port I2C_SCLK  output  1  I2C clock, push-pull; idle 1.
REQ-005 SHALL have port I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or high-Z only, never 1.
REQ-006 SHALL have port vol  output  9  headphone register value of the last started R2 write.
REQ-007 SHALL have port init_done  output  1  high once the 10-word init sequence has completed.

Function
REQ-008 SHALL configure a WM8731 codec at write address byte 8'h34; each word = START, 8'h34, {7-bit reg, data[8]}, data[7:0], STOP; every byte MSB first, each followed by an ACK slot with SDA released.
REQ-009 SHALL send the init table in order (16-bit words): 1E00, 0017, 0217, {7'h02,vol} = 0400|vol, 0812, 0A00, 0C00, 0E02 (I2S, 16-bit, slave), 1000, 1201.
REQ-010 SHALL map VOLUME to the R2 value: 00->9'h130 (mute), 01->9'h15A, 10->9'h16A, 11->9'h179; bit8 = LRHPBOTH, so R3 is not written.
REQ-011 SHALL latch vol from VOLUME at the START of each R2 write.
REQ-012 SHALL time each data/ACK bit as 4 clk_i2c cycles: q0 SCL=0 with SDA updated; q1 SCL=1; q2 SCL=1 with ACK sampled; q3 SCL=0.
REQ-013 SHALL form START as 2 cycles: (SCL=1, SDA=0), then (SCL=0, SDA=0).
REQ-014 SHALL form STOP as 3 cycles: (SCL=0, SDA=0), then (SCL=1, SDA=0), then (SCL=1, SDA=Z).
REQ-015 SHALL insert a 4-cycle GAP (SCL=1, SDA=Z) after every STOP; a word therefore takes 2+27*4+3+4 = 117 cycles.
REQ-016 SHALL on NACK (SDA sampled 1 in an ACK slot) finish the current byte slot, issue STOP+GAP, then resend the same word from START; no retry limit.
REQ-017 SHALL use FSM states IDLE, START, BIT, ACK, STOP, GAP, DONE: IDLE->START after reset release; BIT->ACK after bit 0; ACK->BIT for the next byte, or ->STOP after byte 3 or on NACK; STOP->GAP->START while words remain, else ->DONE.
REQ-018 SHALL set init_done in DONE; in DONE, a VOLUME mapping differing from vol SHALL trigger a single R2 write (START..GAP) and then return to DONE.
REQ-019 SHALL not interrupt a word for a VOLUME change; a change during a word SHALL be honoured once that word completes.

Reset
REQ-020 SHALL while reset is high: I2C_SCLK=1, I2C_SDAT=Z, vol=9'h179, init_done=0, word index=0, state=IDLE, all asynchronously.
REQ-021 SHALL on reset asserted mid-word abandon the word with the bus released, and after release restart from word 0 (1E00).
REQ-022 SHALL leave IDLE on the first clk_i2c edge after reset deassertion.

Structure
REQ-023 SHALL place in a shared package: the 10-entry init table, the codec address constant, the volume map, the FSM state enum, and the phase/gap length constants.
REQ-024 SHALL use one sub-module, i2c_word_writer: it accepts a 24-bit frame with a start strobe and returns done/nack; the sequencer (table index, volume tracking) resides in i2c_audio_config.

Verification
REQ-025 SHALL test reset release with an I2C slave model that always ACKs: 10 words decoded in order 1E00..1201; init_done rises after 1170 cycles; with VOLUME=11, word 3 = 0579.
REQ-026 SHALL test a slave that NACKs the first address byte once: the word is resent, the sequence completes, and 11 frames are observed.
REQ-027 SHALL test VOLUME 11->01 after init_done: exactly one frame 0x34,0x05,0x5A is sent and vol becomes 9'h15A.
REQ-028 SHALL test reset asserted mid-bit of word 5: SCL=1 and SDA=Z immediately; after release the first frame is 1E00.
REQ-029 SHALL test a VOLUME change during word 7 of init: the init sequence is unaltered, and one extra R2 frame follows after init_done.
REQ-030 SHALL check continuously that SDA changes only while SCL=0, except in START/STOP, and that SDA is never driven 1.
